// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the SPI master transaction sequencer.
// Holds the state encoding, bus widths, guard-time defaults and length shaping.
package spi_master_pkg;

    localparam int SPI_LEN_W    = 16;
    localparam int WORD_W       = 32;
    localparam int CS_SETUP_DEF = 2;
    localparam int CS_HOLD_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_HOLD
    } state_e;

    // Command/address length: clamp to one word, round down to whole nibbles in quad mode.
    function automatic logic [5:0] fit_len6(input logic [5:0] len, input logic quad);
        logic [5:0] clamped;
        clamped = (len > 6'd32) ? 6'd32 : len;
        return quad ? {clamped[5:2], 2'b00} : clamped;
    endfunction

    function automatic logic [SPI_LEN_W-1:0] fit_len16(input logic [SPI_LEN_W-1:0] len,
                                                       input logic quad);
        return quad ? {len[SPI_LEN_W-1:2], 2'b00} : len;
    endfunction

    // Right-aligned value moved to the MSBs so the engine shifts it out first.
    function automatic logic [WORD_W-1:0] left_align(input logic [WORD_W-1:0] value,
                                                     input logic [5:0] len);
        return (len == 6'd0) ? '0 : value << (6'd32 - len);
    endfunction

    // Phases run in a fixed order; zero-length phases are skipped.
    function automatic state_e next_phase(input state_e cur,
                                          input logic   cmd_nz,
                                          input logic   addr_nz,
                                          input logic   dummy_nz,
                                          input logic   data_nz);
        state_e nxt;
        nxt = ST_HOLD;
        if (data_nz && (cur inside {ST_SETUP, ST_CMD, ST_ADDR, ST_DUMMY})) nxt = ST_DATA;
        if (dummy_nz && (cur inside {ST_SETUP, ST_CMD, ST_ADDR}))          nxt = ST_DUMMY;
        if (addr_nz && (cur inside {ST_SETUP, ST_CMD}))                     nxt = ST_ADDR;
        if (cmd_nz && (cur == ST_SETUP))                                     nxt = ST_CMD;
        return nxt;
    endfunction

endpackage

// File: rtl/spi_master_seq_cnt.sv
// 16-bit loadable down-counter with a zero flag; times the CS guard
// intervals (counting clk) and the dummy phase (counting SPI edges).
module spi_master_seq_cnt
    import spi_master_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [SPI_LEN_W-1:0] load_val,
    input  logic                 en,
    output logic                 zero
);

    logic [SPI_LEN_W-1:0] cnt_q;
    logic [SPI_LEN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_master_seq.sv
// SPI master transaction sequencer: frames one chip-select transaction per start
// and walks the shift engine through command, address, dummy and write-data phases.
module spi_master_seq
    import spi_master_pkg::*;
#(
    parameter int NUM_CS   = 4,
    parameter int CS_SETUP = CS_SETUP_DEF,
    parameter int CS_HOLD  = CS_HOLD_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      eot,
    input  logic                      cfg_quad,
    input  logic [$clog2(NUM_CS)-1:0] cfg_csn_sel,
    input  logic [31:0]               cfg_cmd,
    input  logic [5:0]                cfg_cmd_len,
    input  logic [31:0]               cfg_addr,
    input  logic [5:0]                cfg_addr_len,
    input  logic [15:0]               cfg_dummy_len,
    input  logic [15:0]               cfg_data_len,
    input  logic [31:0]               wdata,
    input  logic                      wdata_valid,
    output logic                      wdata_ready,
    input  logic                      tx_edge,
    input  logic                      tx_clk_en,
    input  logic                      tx_done,
    input  logic                      tx_data_ready,
    output logic                      tx_en,
    output logic [15:0]               tx_counter,
    output logic                      tx_counter_upd,
    output logic [31:0]               tx_data,
    output logic                      tx_data_valid,
    output logic                      spi_clk_en,
    output logic [NUM_CS-1:0]         spi_csn
);

    localparam int CS_W = $clog2(NUM_CS);

    state_e               state_q,      state_d;
    logic [CS_W-1:0]      csn_sel_q,    csn_sel_d;
    logic                 quad_q,       quad_d;
    logic [WORD_W-1:0]    cmd_q,        cmd_d;
    logic [5:0]           cmd_len_q,    cmd_len_d;
    logic [WORD_W-1:0]    addr_q,       addr_d;
    logic [5:0]           addr_len_q,   addr_len_d;
    logic [SPI_LEN_W-1:0] dummy_len_q,  dummy_len_d;
    logic [SPI_LEN_W-1:0] data_len_q,   data_len_d;
    logic                 phase_first_q, phase_first_d;
    logic                 word_sent_q,  word_sent_d;
    logic                 eot_q,        eot_d;

    logic                 cnt_load;
    logic [SPI_LEN_W-1:0] cnt_val;
    logic                 cnt_en;
    logic                 cnt_zero;
    state_e               after_phase;

    spi_master_seq_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // NOTE: configuration flops are reset along with the FSM so nothing downstream ever sees X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            csn_sel_q     <= '0;
            quad_q        <= 1'b0;
            cmd_q         <= '0;
            cmd_len_q     <= '0;
            addr_q        <= '0;
            addr_len_q    <= '0;
            dummy_len_q   <= '0;
            data_len_q    <= '0;
            phase_first_q <= 1'b0;
            word_sent_q   <= 1'b0;
            eot_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            csn_sel_q     <= csn_sel_d;
            quad_q        <= quad_d;
            cmd_q         <= cmd_d;
            cmd_len_q     <= cmd_len_d;
            addr_q        <= addr_d;
            addr_len_q    <= addr_len_d;
            dummy_len_q   <= dummy_len_d;
            data_len_q    <= data_len_d;
            phase_first_q <= phase_first_d;
            word_sent_q   <= word_sent_d;
            eot_q         <= eot_d;
        end
    end

    assign after_phase = next_phase(state_q, cmd_len_q != '0, addr_len_q != '0,
                                    dummy_len_q != '0, data_len_q != '0);

    // NOTE: every signal gets a default before the case so no branch can infer a latch.
    always_comb begin
        state_d     = state_q;
        csn_sel_d   = csn_sel_q;
        quad_d      = quad_q;
        cmd_d       = cmd_q;
        cmd_len_d   = cmd_len_q;
        addr_d      = addr_q;
        addr_len_d  = addr_len_q;
        dummy_len_d = dummy_len_q;
        data_len_d  = data_len_q;
        eot_d       = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SETUP;
                    csn_sel_d   = cfg_csn_sel;
                    quad_d      = cfg_quad;
                    cmd_d       = cfg_cmd;
                    cmd_len_d   = fit_len6(cfg_cmd_len, cfg_quad);
                    addr_d      = cfg_addr;
                    addr_len_d  = fit_len6(cfg_addr_len, cfg_quad);
                    dummy_len_d = cfg_dummy_len;
                    data_len_d  = fit_len16(cfg_data_len, cfg_quad);
                    cnt_load    = 1'b1;
                    cnt_val     = SPI_LEN_W'(CS_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (cnt_zero) state_d = after_phase;
                else          cnt_en  = 1'b1;
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (tx_done) state_d = after_phase;
            end
            ST_DUMMY: begin
                // Dummy length counts SPI edges, so the counter only advances on tx_edge.
                if (tx_edge) begin
                    if (cnt_zero) state_d = after_phase;
                    else          cnt_en  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    eot_d   = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_DUMMY) && (state_q != ST_DUMMY)) begin
            cnt_load = 1'b1;
            cnt_val  = dummy_len_q - 1'b1;
        end else if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
            cnt_load = 1'b1;
            cnt_val  = SPI_LEN_W'(CS_HOLD - 1);
        end

        phase_first_d = (state_d != state_q) && (state_d inside {ST_CMD, ST_ADDR, ST_DATA});
        word_sent_d   = word_sent_q;
        if (phase_first_d)                       word_sent_d = 1'b0;
        else if (tx_data_valid && tx_data_ready) word_sent_d = 1'b1;
    end

    always_comb begin
        tx_en          = 1'b0;
        tx_counter     = '0;
        tx_counter_upd = 1'b0;
        tx_data        = '0;
        tx_data_valid  = 1'b0;
        spi_clk_en     = 1'b0;
        wdata_ready    = 1'b0;
        spi_csn        = '1;

        unique case (state_q)
            ST_CMD: begin
                tx_en          = 1'b1;
                spi_clk_en     = tx_clk_en;
                tx_counter     = SPI_LEN_W'(cmd_len_q);
                tx_counter_upd = phase_first_q;
                tx_data        = left_align(cmd_q, cmd_len_q);
                // One word per phase, offered only after the target load so the engine never chains.
                tx_data_valid  = !phase_first_q && !word_sent_q;
            end
            ST_ADDR: begin
                tx_en          = 1'b1;
                spi_clk_en     = tx_clk_en;
                tx_counter     = SPI_LEN_W'(addr_len_q);
                tx_counter_upd = phase_first_q;
                tx_data        = left_align(addr_q, addr_len_q);
                tx_data_valid  = !phase_first_q && !word_sent_q;
            end
            ST_DUMMY: begin
                spi_clk_en = 1'b1;
            end
            ST_DATA: begin
                tx_en          = 1'b1;
                spi_clk_en     = tx_clk_en;
                tx_counter     = data_len_q;
                tx_counter_upd = phase_first_q;
                tx_data        = wdata;
                tx_data_valid  = wdata_valid;
                wdata_ready    = tx_data_ready;
            end
            default: ;
        endcase

        if (state_q != ST_IDLE) spi_csn[csn_sel_q] = 1'b0;
    end

    assign busy = (state_q != ST_IDLE);
    assign eot  = eot_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// Scoreboard bench for spi_master_seq with a behavioural shift engine, clock
// divider and TX FIFO; expected phase loads, words and per-transaction totals are queued.
module tb_spi_master_seq;

    localparam int NUM_CS = 4;

    typedef struct {
        int edges;
        int dummy;
        int pops;
        int stall;
        int csn_low;
        int clk_en;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, eot;
    logic        cfg_quad;
    logic [1:0]  cfg_csn_sel;
    logic [31:0] cfg_cmd, cfg_addr;
    logic [5:0]  cfg_cmd_len, cfg_addr_len;
    logic [15:0] cfg_dummy_len, cfg_data_len;
    logic [31:0] wdata;
    logic        wdata_valid, wdata_ready;
    logic        tx_edge, tx_clk_en, tx_done, tx_data_ready;
    logic        tx_en, tx_counter_upd, tx_data_valid, spi_clk_en;
    logic [15:0] tx_counter;
    logic [31:0] tx_data;
    logic [NUM_CS-1:0] spi_csn;

    spi_master_seq #(.NUM_CS(NUM_CS), .CS_SETUP(2), .CS_HOLD(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .eot(eot),
        .cfg_quad(cfg_quad), .cfg_csn_sel(cfg_csn_sel),
        .cfg_cmd(cfg_cmd), .cfg_cmd_len(cfg_cmd_len),
        .cfg_addr(cfg_addr), .cfg_addr_len(cfg_addr_len),
        .cfg_dummy_len(cfg_dummy_len), .cfg_data_len(cfg_data_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .tx_edge(tx_edge), .tx_clk_en(tx_clk_en), .tx_done(tx_done),
        .tx_data_ready(tx_data_ready), .tx_en(tx_en), .tx_counter(tx_counter),
        .tx_counter_upd(tx_counter_upd), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .spi_clk_en(spi_clk_en), .spi_csn(spi_csn)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected", name);
    endtask

    task automatic check_opt(input string name, input int act, input int exp);
        if (exp >= 0) check(name, act, exp);
    endtask

    // Shift engine model: one word per handshake, one bit (nibble in quad) per edge.
    int   eng_rem;
    int   eng_left;
    logic eng_active, eng_have, div_q;

    assign tx_data_ready = eng_active && !eng_have && (eng_rem > 0);
    assign tx_clk_en     = eng_have && (eng_rem > 0);
    assign tx_edge       = spi_clk_en && div_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_rem    <= 0;
            eng_left   <= 0;
            eng_active <= 1'b0;
            eng_have   <= 1'b0;
            div_q      <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            div_q   <= spi_clk_en ? ~div_q : 1'b0;
            tx_done <= 1'b0;
            if (tx_counter_upd) begin
                eng_rem    <= cfg_quad ? int'(tx_counter) / 4 : int'(tx_counter);
                eng_active <= 1'b1;
                eng_have   <= 1'b0;
            end else begin
                if (tx_data_valid && tx_data_ready) begin
                    eng_have <= 1'b1;
                    eng_left <= cfg_quad ? 8 : 32;
                end
                if (tx_edge && tx_en && eng_have && (eng_rem > 0)) begin
                    eng_rem  <= eng_rem - 1;
                    eng_left <= eng_left - 1;
                    if (eng_left == 1) eng_have <= 1'b0;
                    if (eng_rem == 1) begin
                        tx_done    <= 1'b1;
                        eng_active <= 1'b0;
                    end
                end
            end
        end
    end

    // TX FIFO model with an optional forced-empty window ahead of the second word.
    logic [31:0] fifo_mem [0:7];
    logic [2:0]  fifo_wr = '0;
    logic [2:0]  fifo_rd = '0;
    logic        stall_arm = 1'b0;
    int          stall_cnt = 0;
    logic        stall_now;

    assign stall_now   = stall_arm && (fifo_rd == 3'd1) && (stall_cnt < 10);
    assign wdata       = fifo_mem[fifo_rd];
    assign wdata_valid = (fifo_rd != fifo_wr) && !stall_now;

    always @(posedge clk) begin
        if (wdata_ready && wdata_valid) fifo_rd <= fifo_rd + 3'd1;
        if (stall_now && tx_data_ready) stall_cnt <= stall_cnt + 1;
    end

    // Scoreboard queues filled by the stimulus, drained by the monitor.
    logic [15:0] exp_upd [$];
    logic [31:0] exp_word [$];
    txn_t        exp_txn [$];
    logic [1:0]  txn_sel = '0;
    int eot_seen = 0;
    int st_edges, st_dummy, st_pops, st_stall, st_viol, st_bad, st_low, st_clk;

    always @(negedge clk) begin
        if (rst) begin
            st_edges = 0; st_dummy = 0; st_pops = 0; st_stall = 0;
            st_viol  = 0; st_bad   = 0; st_low  = 0; st_clk   = 0;
        end else begin
            if (tx_counter_upd) begin
                if (exp_upd.size() == 0) flag("upd_extra");
                else check("tx_counter", tx_counter, exp_upd.pop_front());
            end
            if (tx_data_valid && tx_data_ready) begin
                if (exp_word.size() == 0) flag("word_extra");
                else check("tx_data", tx_data, exp_word.pop_front());
            end
            if (tx_edge) begin
                st_edges++;
                if (!tx_en) st_dummy++;
            end
            if (wdata_ready && wdata_valid) st_pops++;
            if (tx_data_ready && !tx_data_valid) begin
                st_stall++;
                if (spi_clk_en || (spi_csn == '1)) st_viol++;
            end
            if (spi_csn != (busy ? (4'hF & ~(4'b0001 << txn_sel)) : 4'hF)) st_bad++;
            if (spi_csn != '1) st_low++;
            if (spi_clk_en) st_clk++;
            if (eot) begin
                eot_seen++;
                if (exp_txn.size() == 0) begin
                    flag("eot_extra");
                end else begin
                    txn_t e;
                    e = exp_txn.pop_front();
                    check("edges", st_edges, e.edges);
                    check("dummy_edges", st_dummy, e.dummy);
                    check("fifo_pops", st_pops, e.pops);
                    check("stall_cycles", st_stall, e.stall);
                    check("stall_violations", st_viol, 0);
                    check("csn_pattern_errors", st_bad, 0);
                    check("eot_busy", busy, 0);
                    check_opt("csn_low_cycles", st_low, e.csn_low);
                    check_opt("clk_en_cycles", st_clk, e.clk_en);
                end
                st_edges = 0; st_dummy = 0; st_pops = 0; st_stall = 0;
                st_viol  = 0; st_bad   = 0; st_low  = 0; st_clk   = 0;
            end
        end
    end

    task automatic wait_eots(input int n, input int budget);
        int target;
        bit hit;
        target = eot_seen + n;
        hit    = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(posedge clk);
            if (eot_seen >= target) hit = 1'b1;
        end
        if (!hit) flag("eot_timeout");
    endtask

    task automatic issue(input logic quad, input logic [1:0] sel,
                         input logic [31:0] cmd, input logic [5:0] cmd_len,
                         input logic [31:0] addr, input logic [5:0] addr_len,
                         input logic [15:0] dummy, input logic [15:0] data_len);
        @(negedge clk);
        cfg_quad      = quad;
        cfg_csn_sel   = sel;
        txn_sel       = sel;
        cfg_cmd       = cmd;
        cfg_cmd_len   = cmd_len;
        cfg_addr      = addr;
        cfg_addr_len  = addr_len;
        cfg_dummy_len = dummy;
        cfg_data_len  = data_len;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic txn_t mk(input int edges, input int dummy, input int pops,
                                input int stall, input int csn_low, input int clk_en);
        txn_t t;
        t.edges = edges; t.dummy = dummy; t.pops = pops;
        t.stall = stall; t.csn_low = csn_low; t.clk_en = clk_en;
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  eot_before;
        bit  found;
        rst = 1'b1; start = 1'b0; cfg_quad = 1'b0; cfg_csn_sel = '0;
        cfg_cmd = '0; cfg_cmd_len = '0; cfg_addr = '0; cfg_addr_len = '0;
        cfg_dummy_len = '0; cfg_data_len = '0;
        repeat (3) @(negedge clk);
        check("reset_csn", spi_csn, 4'hF);
        check("reset_busy", busy, 0);
        check("reset_outs", {eot, tx_en, spi_clk_en, wdata_ready, tx_data_valid, tx_counter_upd}, 0);
        rst = 1'b0;

        // Standard read: 8-bit command, 24-bit address.
        exp_upd.push_back(16'd8);  exp_word.push_back(32'h0300_0000);
        exp_upd.push_back(16'd24); exp_word.push_back(32'h1234_5600);
        exp_txn.push_back(mk(32, 0, 0, 0, -1, -1));
        issue(1'b0, 2'd0, 32'h03, 6'd8, 32'h0012_3456, 6'd24, 16'd0, 16'd0);
        wait_eots(1, 2000);

        // Write with FIFO underrun between the two data words.
        fifo_mem[fifo_wr]        = 32'hDEAD_BEEF;
        fifo_mem[fifo_wr + 3'd1] = 32'hCAFE_F00D;
        fifo_wr   = fifo_wr + 3'd2;
        stall_arm = 1'b1;
        exp_upd.push_back(16'd8);  exp_word.push_back(32'h0200_0000);
        exp_upd.push_back(16'd64); exp_word.push_back(32'hDEAD_BEEF);
        exp_word.push_back(32'hCAFE_F00D);
        exp_txn.push_back(mk(72, 0, 2, 10, -1, -1));
        issue(1'b0, 2'd1, 32'h02, 6'd8, 32'h0, 6'd0, 16'd0, 16'd64);
        wait_eots(1, 3000);
        stall_arm = 1'b0;

        // Quad command followed by six dummy clocks.
        exp_upd.push_back(16'd8); exp_word.push_back(32'hEB00_0000);
        exp_txn.push_back(mk(8, 6, 0, 0, -1, -1));
        issue(1'b1, 2'd3, 32'hEB, 6'd8, 32'h0, 6'd0, 16'd6, 16'd0);
        wait_eots(1, 2000);

        // All lengths zero: guard cycles only, no SPI clock.
        exp_txn.push_back(mk(0, 0, 0, 0, 4, 0));
        issue(1'b0, 2'd2, 32'h0, 6'd0, 32'h0, 6'd0, 16'd0, 16'd0);
        wait_eots(1, 200);

        // Command length above one word is clamped to 32.
        exp_upd.push_back(16'd32); exp_word.push_back(32'hAABB_CCDD);
        exp_txn.push_back(mk(32, 0, 0, 0, -1, -1));
        issue(1'b0, 2'd0, 32'hAABB_CCDD, 6'd40, 32'h0, 6'd0, 16'd0, 16'd0);
        wait_eots(1, 2000);

        // Start held high: ignored while busy, re-accepted in the eot cycle.
        exp_upd.push_back(16'd8); exp_word.push_back(32'hA500_0000);
        exp_upd.push_back(16'd8); exp_word.push_back(32'h5A00_0000);
        exp_txn.push_back(mk(8, 0, 0, 0, -1, -1));
        exp_txn.push_back(mk(8, 0, 0, 0, -1, -1));
        @(negedge clk);
        cfg_quad = 1'b0; cfg_csn_sel = 2'd1; txn_sel = 2'd1;
        cfg_cmd = 32'hA5; cfg_cmd_len = 6'd8; cfg_addr_len = 6'd0;
        cfg_dummy_len = 16'd0; cfg_data_len = 16'd0;
        start = 1'b1;
        @(negedge clk);
        cfg_cmd = 32'h5A;
        wait_eots(1, 2000);
        #1 check("b2b_restart_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        wait_eots(1, 2000);

        // Reset during the address phase: CSn releases at once, no eot.
        exp_upd.push_back(16'd8);  exp_word.push_back(32'h9F00_0000);
        exp_upd.push_back(16'd24); exp_word.push_back(32'hABCD_EF00);
        exp_txn.push_back(mk(32, 0, 0, 0, -1, -1));
        issue(1'b0, 2'd3, 32'h9F, 6'd8, 32'h00AB_CDEF, 6'd24, 16'd0, 16'd0);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (tx_counter_upd && (tx_counter == 16'd24)) found = 1'b1;
        end
        if (!found) flag("addr_phase_timeout");
        repeat (6) @(negedge clk);
        eot_before = eot_seen;
        rst = 1'b1;
        #1;
        check("rst_mid_csn", spi_csn, 4'hF);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_eot", eot, 0);
        exp_upd.delete(); exp_word.delete(); exp_txn.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_eot", eot_seen, eot_before);

        // Clean transaction after the reset.
        exp_upd.push_back(16'd8);  exp_word.push_back(32'h0B00_0000);
        exp_upd.push_back(16'd24); exp_word.push_back(32'h0004_0000);
        exp_txn.push_back(mk(32, 0, 0, 0, -1, -1));
        issue(1'b0, 2'd0, 32'h0B, 6'd8, 32'h0000_0400, 6'd24, 16'd0, 16'd0);
        wait_eots(1, 2000);

        repeat (5) @(negedge clk);
        check("leftover_expect", exp_upd.size() + exp_word.size() + exp_txn.size(), 0);
        check("eot_total", eot_seen, 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
